rom_secuenciador: RTL and testbench

// - Upstream address sequencer for the 8-bit combinational ROM (Dir[7:0] -> Dato_s[7:0]).
// - On start, walks a run of consecutive ROM addresses and registers each byte.
// - Streams each byte downstream with a valid/ready handshake.
// - Accumulates a 16-bit checksum of the run and pulses fin when the run completes.

---
 rtl/rom_secuenciador.sv | 147 ++++++++++++++
 tb/tb_rom_secuenciador.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/rom_secuenciador.sv
// -----------------------------------------------------------------------------
// rom_secuenciador
//
// Address sequencer placed in front of a combinational ROM. When started it
// walks a run of consecutive ROM addresses and registers each byte. Each byte
// is streamed downstream over a valid/ready handshake. A checksum of the
// transferred bytes is accumulated, and fin pulses once when the run is done.
//
// Ports
//   clk        in   1            rising-edge clock
//   rst_n      in   1            asynchronous active-low reset
//   start      in   1            start request, sampled only while idle
//   base_dir   in   ANCHO_DIR    first address of the run (sampled with start)
//   cuenta     in   ANCHO_DIR    word count, 0 means 2**ANCHO_DIR (sampled with start)
//   Dir        out  ANCHO_DIR    address presented to the ROM
//   Dato_s     in   ANCHO_DATO   ROM data, combinational from Dir
//   dato_o     out  ANCHO_DATO   registered ROM byte sent downstream
//   valido_o   out  1            dato_o is valid
//   listo_i    in   1            downstream ready
//   ocupado    out  1            high in every state except INACTIVO
//   suma       out  ANCHO_SUMA   running sum of transferred bytes (wraps)
//   fin        out  1            one-cycle pulse after the last transfer
//   estado_dbg out  2            current FSM state, for observation
//
// Handshake: a word moves on a rising edge where valido_o and listo_i are both
// high. While valido_o is high and listo_i is low, dato_o and Dir hold and
// valido_o does not drop. listo_i is ignored while valido_o is low.
// -----------------------------------------------------------------------------
module rom_secuenciador #(
  parameter int ANCHO_DIR  = 8,
  parameter int ANCHO_DATO = 8,
  parameter int ANCHO_SUMA = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ANCHO_DIR-1:0]  base_dir,
  input  logic [ANCHO_DIR-1:0]  cuenta,
  output logic [ANCHO_DIR-1:0]  Dir,
  input  logic [ANCHO_DATO-1:0] Dato_s,
  output logic [ANCHO_DATO-1:0] dato_o,
  output logic                  valido_o,
  input  logic                  listo_i,
  output logic                  ocupado,
  output logic [ANCHO_SUMA-1:0] suma,
  output logic                  fin,
  output logic [1:0]            estado_dbg
);

  typedef enum logic [1:0] {
    INACTIVO = 2'd0,
    LEER     = 2'd1,
    SALIDA   = 2'd2,
    FIN      = 2'd3
  } estado_t;

  estado_t                 r_estado;
  estado_t                 w_estado_sig;

  logic [ANCHO_DIR-1:0]    r_dir;
  // One bit wider than the address so a count of 0 can stand for a full sweep.
  logic [ANCHO_DIR:0]      r_restante;
  logic [ANCHO_DATO-1:0]   r_dato;
  logic                    r_valido;
  logic [ANCHO_SUMA-1:0]   r_suma;

  logic                    w_arranque;
  logic                    w_xfer;
  logic                    w_ultima;
  logic [ANCHO_DIR:0]      w_carga;
  logic                    w_ocupado;
  logic                    w_fin;

  assign w_arranque = (r_estado == INACTIVO) && start;
  assign w_xfer     = (r_estado == SALIDA) && r_valido && listo_i;
  assign w_ultima   = (r_restante == (ANCHO_DIR+1)'(1));
  assign w_carga    = (cuenta == '0) ? {1'b1, {ANCHO_DIR{1'b0}}} : {1'b0, cuenta};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estado <= INACTIVO;
    end else begin
      r_estado <= w_estado_sig;
    end
  end

  // Next-state logic
  always_comb begin
    w_estado_sig = r_estado;
    case (r_estado)
      INACTIVO: if (start)  w_estado_sig = LEER;
      LEER:                 w_estado_sig = SALIDA;
      SALIDA:   if (w_xfer) w_estado_sig = w_ultima ? FIN : LEER;
      FIN:                  w_estado_sig = INACTIVO;
      default:              w_estado_sig = INACTIVO;
    endcase
  end

  // State-decoded outputs (decoded straight from the state register)
  always_comb begin
    w_ocupado = 1'b1;
    w_fin     = 1'b0;
    case (r_estado)
      INACTIVO: w_ocupado = 1'b0;
      FIN:      w_fin     = 1'b1;
      default:  w_ocupado = 1'b1;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dir      <= '0;
      r_restante <= '0;
      r_dato     <= '0;
      r_valido   <= 1'b0;
      r_suma     <= '0;
    end else begin
      if (w_arranque) begin
        r_dir      <= base_dir;
        r_restante <= w_carga;
        r_suma     <= '0;
      end
      // Dir has been stable for the whole LEER cycle, so Dato_s has settled.
      if (r_estado == LEER) begin
        r_dato   <= Dato_s;
        r_valido <= 1'b1;
      end
      if (w_xfer) begin
        r_suma     <= r_suma + {{(ANCHO_SUMA-ANCHO_DATO){1'b0}}, r_dato};
        r_valido   <= 1'b0;
        r_dir      <= r_dir + ANCHO_DIR'(1);
        r_restante <= r_restante - (ANCHO_DIR+1)'(1);
      end
    end
  end

  assign Dir        = r_dir;
  assign dato_o     = r_dato;
  assign valido_o   = r_valido;
  assign suma       = r_suma;
  assign ocupado    = w_ocupado;
  assign fin        = w_fin;
  assign estado_dbg = r_estado;

endmodule

// File: tb/tb_rom_secuenciador.sv
// -----------------------------------------------------------------------------
// tb_rom_secuenciador
//
// Drives runs of the sequencer against a ROM model held in an array. For each
// run the expected {address, byte} stream, the final checksum and the final
// address are computed from the ROM contents with plain arithmetic and queued.
// A monitor on the falling edge pops and compares on every transfer and on fin.
// -----------------------------------------------------------------------------
module tb_rom_secuenciador;

  // Clock / reset
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  // DUT signals
  logic        start = 1'b0;
  logic [7:0]  base_dir = '0;
  logic [7:0]  cuenta = '0;
  logic [7:0]  Dir;
  logic [7:0]  Dato_s;
  logic [7:0]  dato_o;
  logic        valido_o;
  logic        listo_i = 1'b0;
  logic        ocupado;
  logic [15:0] suma;
  logic        fin;
  logic [1:0]  estado_dbg;

  // ROM model, combinational from Dir
  logic [7:0]  rom [256];
  assign Dato_s = rom[Dir];

  rom_secuenciador #(
    .ANCHO_DIR (8),
    .ANCHO_DATO(8),
    .ANCHO_SUMA(16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_dir  (base_dir),
    .cuenta    (cuenta),
    .Dir       (Dir),
    .Dato_s    (Dato_s),
    .dato_o    (dato_o),
    .valido_o  (valido_o),
    .listo_i   (listo_i),
    .ocupado   (ocupado),
    .suma      (suma),
    .fin       (fin),
    .estado_dbg(estado_dbg)
  );

  // Scoreboard state
  logic [15:0] exp_q[$];       // {address, byte} per expected transfer
  logic [15:0] exp_suma_q[$];  // checksum expected at fin
  logic [7:0]  exp_end_dir;
  int          fin_count = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor
  logic        held_v = 1'b0;
  logic [15:0] held_val = '0;
  logic        prev_fin = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      held_v   = 1'b0;
      prev_fin = 1'b0;
    end else begin
      if (held_v) begin
        chk("valid_held", valido_o, 1'b1);
        chk("hold_dir_dato", {Dir, dato_o}, held_val);
      end
      if (prev_fin) begin
        chk("fin_one_cycle", fin, 1'b0);
        chk("ocupado_after_fin", ocupado, 1'b0);
      end
      if (valido_o && listo_i) begin
        if (exp_q.size() == 0) chk("unexpected_transfer", 1, 0);
        else chk("transfer_dir_dato", {Dir, dato_o}, exp_q.pop_front());
      end
      held_v   = valido_o && !listo_i;
      held_val = {Dir, dato_o};
      if (fin) begin
        fin_count++;
        chk("fin_ocupado", ocupado, 1'b1);
        chk("fin_drained", exp_q.size(), 0);
        chk("fin_dir", Dir, exp_end_dir);
        if (exp_suma_q.size() == 0) chk("unexpected_fin", 1, 0);
        else chk("fin_suma", suma, exp_suma_q.pop_front());
      end
      prev_fin = fin;
    end
  end

  // Driver: one complete run with optional backpressure and start abuse
  task automatic run_seq(input logic [7:0] b, input logic [7:0] c,
                         input int hold_n, input int bp_pct, input bit abuse);
    int          n;
    int          f0;
    bit          done;
    logic [15:0] s;
    logic [7:0]  a;
    n = (c == 8'd0) ? 256 : int'(c);
    s = '0;
    for (int i = 0; i < n; i++) begin
      a = b + 8'(i);
      exp_q.push_back({a, rom[a]});
      s = s + {8'd0, rom[a]};
    end
    exp_suma_q.push_back(s);
    exp_end_dir = b + 8'(n);
    f0   = fin_count;
    done = 1'b0;
    @(posedge clk); #1;
    base_dir = b;
    cuenta   = c;
    start    = 1'b1;
    listo_i  = (hold_n == 0);
    @(posedge clk); #1;
    start    = 1'b0;
    base_dir = 8'($urandom);
    cuenta   = 8'($urandom);
    for (int cyc = 0; cyc < n * 10 + 40; cyc++) begin
      if (fin_count != f0 && !ocupado) begin
        done = 1'b1;
        break;
      end
      listo_i = (cyc < hold_n) ? 1'b0 : ($urandom_range(0, 99) >= bp_pct);
      start   = abuse && ($urandom_range(0, 5) == 0);
      @(posedge clk); #1;
    end
    start   = 1'b0;
    listo_i = 1'b0;
    chk("run_done", done, 1'b1);
    chk("fin_count", fin_count - f0, 1);
    if (!done) begin
      exp_q.delete();
      exp_suma_q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
    chk("suma_holds", suma, s);
    chk("idle_after_run", {ocupado, valido_o}, 2'b00);
  endtask

  // Start a run, reach SALIDA under backpressure, then reset asynchronously
  task automatic abort_run(input logic [7:0] b, input logic [7:0] c);
    int f0;
    f0 = fin_count;
    @(posedge clk); #1;
    base_dir = b;
    cuenta   = c;
    start    = 1'b1;
    listo_i  = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 10 && !valido_o; i++) begin
      @(posedge clk); #1;
    end
    chk("abort_reached_valid", valido_o, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_outputs_zero", {Dir, dato_o, valido_o, ocupado, suma, fin}, 35'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_fin", fin_count - f0, 0);
    chk("abort_idle", ocupado, 1'b0);
  endtask

  // Main sequence and final report
  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom_range(0, 255));
    rom[0]  = 8'd90;
    rom[1]  = 8'd80;
    rom[2]  = 8'd40;
    rom[3]  = 8'd60;
    rom[9]  = 8'd100;
    rom[10] = 8'd101;
    rom[11] = 8'd102;

    #12;
    chk("reset_outputs", {Dir, dato_o, valido_o, ocupado, suma, fin}, 35'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_after_reset", {ocupado, valido_o, fin}, 3'b000);

    // Basic run: 90, 80, 40, 60 -> 270, Dir ends at 4
    run_seq(8'd0, 8'd4, 0, 0, 1'b0);
    // Backpressure on the first word: 80 held, then 40 -> 120
    run_seq(8'd1, 8'd2, 5, 0, 1'b0);
    // Tail: 100, 101, 102 -> 303
    run_seq(8'd9, 8'd3, 0, 0, 1'b0);
    // Address wrap 255 -> 0
    run_seq(8'd255, 8'd2, 0, 0, 1'b0);
    // Full sweep with start pulses mid-run
    run_seq(8'($urandom), 8'd0, 0, 0, 1'b1);
    // Reset in SALIDA, then a clean run from a new base
    abort_run(8'd40, 8'd5);
    run_seq(8'd200, 8'd6, 0, 20, 1'b1);
    // Random runs with random backpressure
    for (int r = 0; r < 6; r++) begin
      run_seq(8'($urandom), 8'($urandom_range(1, 24)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 60)), 1'b1);
    end
    run_seq(8'($urandom), 8'd0, 0, 30, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
